led_cmd_exec: RTL and testbench
===============================

# led_cmd_exec

Command execution stage between `spi_slave` and the PWM bank. It captures each decoded frame (cmd/addr/payload) when the SPI slave flags a completed transaction with chip-select released. It executes LED_SET (immediate or ramped) and LED_READ against an internal brightness register file, and drives the per-LED 7-bit duty values into the `pwm` instances. For LED_READ it also prepares the response frame and transmit enable for the SPI slave.

## Interface
- `NUM_LEDS`, 8: number of LED channels.
- `CMD_W`, 8: command field width (`CMD_BITS`).
- `ADDR_W`, 8: address field width (`ADDR_BITS`).
- `PAYLOAD_W`, 8: payload width (`PAYLOAD_BITS`); bits [7:1] are brightness, bit [0] is the ramp flag.
- `FRAME_W`, 24: response frame width (`MASTER_FRAME_WIDTH`) = CMD_W+ADDR_W+PAYLOAD_W.
- `RAMP_DIV`, 1000: sysclk cycles per ramp step, ≥2.

Ports:
- `sysclk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_cs` in 1: SPI chip select; high = `CS_DEASSERT`.
- `i_rx_dv` in 1: frame-valid level from `spi_slave`.
- `i_cmd` in CMD_W, `i_addr` in ADDR_W, `i_payload` in PAYLOAD_W: decoded frame fields.
- `o_brightness` out NUM_LEDS*7: current duty per LED, LED k at [7k+6:7k].
- `o_tx_frame` out FRAME_W: response frame {cmd, addr, payload}.
- `o_tx_enb` out 1: response valid, drives `slv_tx_enb`.
- `o_busy` out 1: high while any LED current ≠ target.
- `o_err` out 1: one-cycle pulse on a rejected command.
- `o_err_cnt` out 8: saturating count of rejected commands.

## Operation
- Reset: all current/target = 0, prescaler = 0, state IDLE, `o_tx_frame` = 0, `o_tx_enb`/`o_err`/`o_busy` = 0, `o_err_cnt` = 0.
- Trigger: a rising edge of `i_rx_dv` (registered previous value) sampled while `i_cs` = 1. A level held high gives one trigger. An edge while `i_cs` = 0 is ignored and does not re-arm.
- FSM IDLE → EXEC → (RESP | IDLE):
  - IDLE: on trigger, latch cmd/addr/payload into internal registers; go to EXEC.
  - EXEC (1 cycle), by command:
    - `CMD_LED_SET`, addr < NUM_LEDS: target[addr] ← payload[7:1]. If payload[0] = 0, current[addr] ← payload[7:1] as well. Go to IDLE.
    - `CMD_LED_READ`, addr < NUM_LEDS: load `o_tx_frame` ← {`CMD_LED_READ`, addr, current[addr], (current==target)}. Go to RESP.
    - `CMD_NOP`: no action; go to IDLE.
    - Unknown command, or addr ≥ NUM_LEDS on SET/READ: no state change; pulse `o_err`; `o_err_cnt`++ (saturates at 255). A rejected READ loads `o_tx_frame` ← {`CMD_LED_READ`, addr, 8'h00} and goes to RESP; everything else goes to IDLE.
  - RESP: `o_tx_enb` = 1 and `o_tx_frame` is held stable. Exit to IDLE when `i_cs` rises after having been low in RESP. A trigger seen in RESP also ends RESP, and that frame is latched in the same cycle (go to EXEC). `o_tx_enb` = 0 in the cycle after exit.
- Ramp engine:
  - The prescaler counts 0..RAMP_DIV-1 and wraps. A tick occurs on the count RAMP_DIV-1.
  - On a tick, every LED with current < target increments by 1, and every LED with current > target decrements by 1.
  - No overflow is possible: values stay within 0..127.
- Simultaneous tick and EXEC write to the same LED: the EXEC write wins and that LED skips the tick. Other LEDs step normally.
- SET to an LED mid-ramp: only the target is replaced; current continues from its present value.
- `o_busy` = OR over LEDs of (current ≠ target), registered.

## Timing
- Trigger sampled at cycle N; EXEC at N+1; the register-file and `o_brightness` update is visible at N+2.
- READ: `o_tx_frame` valid at N+2; `o_tx_enb` rises at N+2.
- `o_err` is high during cycle N+2 only.
- Ramp from 0 to 127 takes 127 ticks = 127·RAMP_DIV cycles.
- Minimum trigger spacing is 2 cycles; a trigger during EXEC is dropped.
- Asserting `rst_n` mid-ramp or in RESP immediately zeroes all outputs.

## Test plan
- Reset, then SET addr 3, payload 8'hC8 (7'd100, no ramp) → `o_brightness` LED3 = 100 at N+2; other LEDs stay 0; `o_busy` = 0.
- RAMP_DIV=4, SET addr 0, payload 8'h15 (7'd10, ramp) → LED0 rises by 1 every 4 cycles and reaches 10 after 40 cycles; `o_busy` = 1 until then.
- After LED5 = 42, READ addr 5 → `o_tx_frame` = {`CMD_LED_READ`, 8'h05, 8'h55}, `o_tx_enb` = 1. Drive a `i_cs` low→high pulse → `o_tx_enb` = 0 one cycle later.
- SET addr 8 and unknown cmd 8'hEE → no LED change, `o_err` pulses twice, `o_err_cnt` = 2; 300 bad frames → `o_err_cnt` = 255.
- `i_rx_dv` held high for 10 cycles, and a second edge with `i_cs` = 0 → exactly one execution.
- Assert `rst_n` low mid-ramp with `o_tx_enb` = 1 → all brightness values, `o_tx_enb` and `o_busy` = 0 asynchronously.

Source files
------------

// File: rtl/led_cmd_exec.sv
// Command execution stage: captures SPI frames, runs LED SET/READ against the
// brightness register file, ramps current toward target, and builds READ responses.
module led_cmd_exec #(
  parameter int NUM_LEDS  = 8,
  parameter int CMD_W     = 8,
  parameter int ADDR_W    = 8,
  parameter int PAYLOAD_W = 8,
  parameter int FRAME_W   = CMD_W + ADDR_W + PAYLOAD_W,
  parameter int RAMP_DIV  = 1000,
  parameter logic [CMD_W-1:0] CMD_NOP      = CMD_W'(0),
  parameter logic [CMD_W-1:0] CMD_LED_SET  = CMD_W'(1),
  parameter logic [CMD_W-1:0] CMD_LED_READ = CMD_W'(2)
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  i_cs,
  input  logic                  i_rx_dv,
  input  logic [CMD_W-1:0]      i_cmd,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [PAYLOAD_W-1:0]  i_payload,
  output logic [NUM_LEDS*7-1:0] o_brightness,
  output logic [FRAME_W-1:0]    o_tx_frame,
  output logic                  o_tx_enb,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [7:0]            o_err_cnt
);
  localparam int PW = $clog2(RAMP_DIV);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q;
  logic                  rx_dv_q, cs_low_q, tx_enb_q, err_q, busy_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [PAYLOAD_W-1:0]  payload_q;
  logic [PW-1:0]         presc_q;
  logic [FRAME_W-1:0]    tx_frame_q;
  logic [7:0]            err_cnt_q;

  logic                  trigger, tick, addr_ok, set_ok;
  logic [NUM_LEDS*7-1:0] cur_all;
  logic [NUM_LEDS-1:0]   eq_all, diff_next;
  logic [6:0]            rd_cur;
  logic                  rd_eq;

  assign trigger = i_rx_dv & ~rx_dv_q & i_cs;
  assign tick    = (presc_q == PW'(RAMP_DIV - 1));
  assign addr_ok = (32'(addr_q) < NUM_LEDS);
  assign set_ok  = (state_q == EXEC) && (cmd_q == CMD_LED_SET) && addr_ok;

  // Per-LED current/target pair; an EXEC SET to this LED overrides the ramp tick.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    logic [6:0] cur_q, cur_d, tgt_q, tgt_d;
    logic       hit;

    assign hit = set_ok && (32'(addr_q) == gi);

    always_comb begin
      cur_d = cur_q;
      tgt_d = tgt_q;
      if (hit) begin
        tgt_d = payload_q[7:1];
        if (!payload_q[0]) cur_d = payload_q[7:1];
      end else if (tick) begin
        if (cur_q < tgt_q)      cur_d = cur_q + 7'd1;
        else if (cur_q > tgt_q) cur_d = cur_q - 7'd1;
      end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        cur_q <= '0;
        tgt_q <= '0;
      end else begin
        cur_q <= cur_d;
        tgt_q <= tgt_d;
      end
    end

    assign cur_all[7*gi +: 7] = cur_q;
    assign eq_all[gi]         = (cur_q == tgt_q);
    assign diff_next[gi]      = (cur_d != tgt_d);
  end

  always_comb begin
    rd_cur = '0;
    rd_eq  = 1'b0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (32'(addr_q) == k) begin
        rd_cur = cur_all[7*k +: 7];
        rd_eq  = eq_all[k];
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_dv_q    <= 1'b0;
      cs_low_q   <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      payload_q  <= '0;
      presc_q    <= '0;
      tx_frame_q <= '0;
      tx_enb_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      rx_dv_q <= i_rx_dv;
      presc_q <= tick ? '0 : presc_q + PW'(1);
      busy_q  <= |diff_next;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            cmd_q     <= i_cmd;
            addr_q    <= i_addr;
            payload_q <= i_payload;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (cmd_q == CMD_LED_SET && addr_ok) begin
            state_q <= IDLE;
          end else if (cmd_q == CMD_LED_READ && addr_ok) begin
            tx_frame_q <= {CMD_LED_READ, addr_q, rd_cur, rd_eq};
            tx_enb_q   <= 1'b1;
            cs_low_q   <= 1'b0;
            state_q    <= RESP;
          end else if (cmd_q == CMD_NOP) begin
            state_q <= IDLE;
          end else begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (cmd_q == CMD_LED_READ) begin
              tx_frame_q <= {CMD_LED_READ, addr_q, PAYLOAD_W'(0)};
              tx_enb_q   <= 1'b1;
              cs_low_q   <= 1'b0;
              state_q    <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RESP: begin
          // A new frame pre-empts the response; otherwise wait for a full CS low->high.
          if (trigger) begin
            cmd_q     <= i_cmd;
            addr_q    <= i_addr;
            payload_q <= i_payload;
            tx_enb_q  <= 1'b0;
            state_q   <= EXEC;
          end else if (i_cs && cs_low_q) begin
            tx_enb_q <= 1'b0;
            state_q  <= IDLE;
          end else if (!i_cs) begin
            cs_low_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_brightness = cur_all;
  assign o_tx_frame   = tx_frame_q;
  assign o_tx_enb     = tx_enb_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;
  assign o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_led_cmd_exec.sv
// Randomized scoreboard bench for led_cmd_exec against a per-cycle behavioural LED model.
module tb_led_cmd_exec;
  localparam int N  = 8;
  localparam int RD = 4;

  logic         sysclk = 1'b0;
  logic         rst_n  = 1'b0;
  logic         i_cs = 1'b1, i_rx_dv = 1'b0;
  logic [7:0]   i_cmd = '0, i_addr = '0, i_payload = '0;
  logic [N*7-1:0] o_brightness;
  logic [23:0]  o_tx_frame;
  logic         o_tx_enb, o_busy, o_err;
  logic [7:0]   o_err_cnt;

  led_cmd_exec #(.NUM_LEDS(N), .RAMP_DIV(RD)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .i_cs(i_cs), .i_rx_dv(i_rx_dv),
    .i_cmd(i_cmd), .i_addr(i_addr), .i_payload(i_payload),
    .o_brightness(o_brightness), .o_tx_frame(o_tx_frame), .o_tx_enb(o_tx_enb),
    .o_busy(o_busy), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0, errors = 0;

  // Reference model state
  int m_cur [N], m_tgt [N];
  int m_presc, m_err, m_cmd, m_addr, m_pay;
  bit m_pend, m_prev, m_tick;
  bit m_wr [N];
  int exp_frames [$];
  int exp_err [$];
  bit prev_enb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_busy();
    for (int k = 0; k < N; k++) if (m_cur[k] != m_tgt[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_cur[k] = 0; m_tgt[k] = 0; end
    m_presc = 0; m_err = 0; m_pend = 0; m_prev = 0;
    exp_frames.delete(); exp_err.delete();
  endtask

  // Model: frames take effect one edge after capture; ticks every RD cycles.
  always @(posedge sysclk) begin
    if (rst_n) begin
      m_tick  = (m_presc == RD - 1);
      m_presc = m_tick ? 0 : m_presc + 1;
      for (int k = 0; k < N; k++) m_wr[k] = 0;
      if (m_pend) begin
        m_pend = 0;
        if (m_cmd == 1 && m_addr < N) begin
          m_tgt[m_addr] = m_pay / 2;
          if (m_pay % 2 == 0) m_cur[m_addr] = m_pay / 2;
          m_wr[m_addr] = 1;
        end else if (m_cmd == 2 && m_addr < N) begin
          exp_frames.push_back((2 << 16) + (m_addr << 8) + (m_cur[m_addr] * 2)
                               + ((m_cur[m_addr] == m_tgt[m_addr]) ? 1 : 0));
        end else if (m_cmd != 0) begin
          if (m_err < 255) m_err++;
          exp_err.push_back(m_err);
          if (m_cmd == 2) exp_frames.push_back((2 << 16) + (m_addr << 8));
        end
      end else if (i_rx_dv && !m_prev && i_cs) begin
        m_pend = 1; m_cmd = int'(i_cmd); m_addr = int'(i_addr); m_pay = int'(i_payload);
      end
      for (int k = 0; k < N; k++) begin
        if (m_tick && !m_wr[k]) begin
          if (m_cur[k] < m_tgt[k]) m_cur[k]++;
          else if (m_cur[k] > m_tgt[k]) m_cur[k]--;
        end
      end
      m_prev = i_rx_dv;
    end
  end

  // Monitor: per-cycle brightness/busy, plus scoreboard pops on response and error events.
  always @(negedge sysclk) begin
    logic [N*7-1:0] exp_b;
    int e;
    if (rst_n) begin
      for (int k = 0; k < N; k++) exp_b[7*k +: 7] = 7'(m_cur[k]);
      chk("brightness", 64'(o_brightness), 64'(exp_b));
      chk("busy", 64'(o_busy), 64'(model_busy()));
      if (o_tx_enb && !prev_enb) begin
        if (exp_frames.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_frame: unexpected response %0h, none expected", o_tx_frame);
        end else begin
          e = exp_frames.pop_front();
          chk("tx_frame", 64'(o_tx_frame), 64'(e));
        end
      end
      if (o_err) begin
        if (exp_err.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_pulse: unexpected err, cnt %0d, none expected", o_err_cnt);
        end else begin
          e = exp_err.pop_front();
          chk("err_cnt_at_pulse", 64'(o_err_cnt), 64'(e));
        end
      end
    end
    prev_enb = o_tx_enb;
  end

  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p, input int gap);
    @(negedge sysclk);
    i_cmd = c; i_addr = a; i_payload = p; i_cs = 1'b1; i_rx_dv = 1'b1;
    @(negedge sysclk);
    i_rx_dv = 1'b0;
    repeat (gap) @(negedge sysclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_brightness", 64'(o_brightness), 64'd0);
    chk("rst_tx_frame", 64'(o_tx_frame), 64'd0);
    chk("rst_tx_enb", 64'(o_tx_enb), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    rst_n = 1'b1;

    // Immediate set
    send(8'h01, 8'd3, 8'hC8, 1);
    chk("led3_immediate", 64'(o_brightness[27:21]), 64'd100);
    chk("others_zero", 64'(o_brightness & ~(56'h7F << 21)), 64'd0);
    chk("busy_after_imm", 64'(o_busy), 64'd0);

    // Ramped set
    send(8'h01, 8'd0, 8'h15, 1);
    chk("busy_during_ramp", 64'(o_busy), 64'd1);
    repeat (45) @(negedge sysclk);
    chk("led0_ramped", 64'(o_brightness[6:0]), 64'd10);
    chk("busy_after_ramp", 64'(o_busy), 64'd0);

    // Read with CS handshake
    send(8'h01, 8'd5, 8'h54, 1);
    send(8'h02, 8'd5, 8'h00, 2);
    chk("read_tx_enb", 64'(o_tx_enb), 64'd1);
    chk("read_frame", 64'(o_tx_frame), 64'h020555);
    @(negedge sysclk); i_cs = 1'b0;
    @(negedge sysclk); i_cs = 1'b1;
    chk("tx_enb_held", 64'(o_tx_enb), 64'd1);
    @(negedge sysclk);
    chk("tx_enb_exit", 64'(o_tx_enb), 64'd0);

    // Rejected commands and saturation
    send(8'h01, 8'd8, 8'h10, 1);
    send(8'hEE, 8'd3, 8'h00, 1);
    chk("err_cnt_two", 64'(o_err_cnt), 64'd2);
    chk("led3_untouched", 64'(o_brightness[27:21]), 64'd100);
    for (int i = 0; i < 298; i++) send(8'hEE, 8'(i), 8'h00, 1);
    chk("err_cnt_sat", 64'(o_err_cnt), 64'd255);

    // Held rx_dv and edge with CS low
    @(negedge sysclk);
    i_cmd = 8'h01; i_addr = 8'd1; i_payload = 8'h20; i_rx_dv = 1'b1;
    repeat (10) @(negedge sysclk);
    i_rx_dv = 1'b0;
    repeat (2) @(negedge sysclk);
    i_cs = 1'b0; i_cmd = 8'h01; i_addr = 8'd2; i_payload = 8'h40; i_rx_dv = 1'b1;
    repeat (2) @(negedge sysclk);
    i_rx_dv = 1'b0;
    @(negedge sysclk); i_cs = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("held_dv_led1", 64'(o_brightness[13:7]), 64'd16);
    chk("cs_low_led2", 64'(o_brightness[20:14]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3)      send(8'h01, 8'($urandom_range(0, 9)), 8'($urandom), int'($urandom_range(1, 5)));
      else if (r <= 6) send(8'h02, 8'($urandom_range(0, 9)), 8'($urandom), int'($urandom_range(1, 5)));
      else if (r == 7) send(8'h00, 8'($urandom), 8'($urandom), int'($urandom_range(1, 5)));
      else             send(8'($urandom_range(3, 255)), 8'($urandom), 8'($urandom), int'($urandom_range(1, 5)));
    end
    repeat (20) @(negedge sysclk);
    chk("frames_drained", 64'(exp_frames.size()), 64'd0);
    chk("errs_drained", 64'(exp_err.size()), 64'd0);

    // Async reset mid-ramp while responding
    send(8'h01, 8'd6, 8'hFF, 1);
    send(8'h02, 8'd4, 8'h00, 3);
    chk("pre_rst_tx_enb", 64'(o_tx_enb), 64'd1);
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_brightness", 64'(o_brightness), 64'd0);
    chk("async_tx_enb", 64'(o_tx_enb), 64'd0);
    chk("async_busy", 64'(o_busy), 64'd0);
    chk("async_err_cnt", 64'(o_err_cnt), 64'd0);
    model_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
